// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int FETCH_AW = 32;
  localparam int FETCH_DW = 32;

  localparam logic [FETCH_AW-1:0] PC_RESET = '0;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  // Handshake outcome of a cycle, as seen by the occupancy counter.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fq_op_e;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x W storage array: synchronous write, asynchronous read, no data reset.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between IF and ID with flush on taken jump.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = FETCH_AW,
  parameter int DW    = FETCH_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_pc,
  input  logic [DW-1:0]            in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [AW-1:0]            out_pc,
  output logic [DW-1:0]            out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty;
  logic          bypass;
  logic          bypass_take;
  logic          push;
  logic          pop_mem;
  logic [EW-1:0] rd_data;
  fq_op_e        op;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != CW'(DEPTH));
  assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass      = empty & in_valid & ~flush;
  assign bypass_take = bypass & out_ready;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // A bypassed pair consumed in the same cycle is never written.
  assign push    = in_valid & in_ready & ~flush & ~bypass_take;
  assign pop_mem = ~empty & out_ready & ~flush;
  assign op      = fq_op_e'({push, pop_mem});

  always_comb begin
    out_valid = ~empty | bypass;
    out_pc    = AW'(PC_RESET);
    out_instr = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (!empty) begin
      out_pc    = rd_data[EW-1:DW];
      out_instr = rd_data[DW-1:0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_mem) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case (op)
        OP_PUSH: count_d = count_q + CW'(1);
        OP_POP:  count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction prefetch buffer between the IF program counter / instruction memory and the ID stage.
- Accepts one {pc, instr} pair per cycle from fetch and presents pairs in order to decode.
- Decouples decode backpressure from the PC: the PC stall is driven from `in_ready`.
- Flushed on a taken jump so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 32, PC width (word address; PC increments by 1 per instruction).
- DW, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  taken jump (jump_cs); discard all contents.
- in_valid  in  1  fetch presents a pair this cycle.
- in_pc  in  AW  PC of the fetched instruction.
- in_instr  in  DW  fetched instruction word.
- in_ready  out  1  queue can accept; PC stall = in_valid & ~in_ready.
- out_valid  out  1  head entry valid.
- out_pc  out  AW  head PC.
- out_instr  out  DW  head instruction.
- out_ready  in  1  decode accepts head (not stalled).
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - count=0, read/write pointers=0, out_valid=0, in_ready=1.
  - out_pc=0, out_instr=0 (storage need not be cleared, but outputs must read 0 while empty).
- Push occurs when in_valid & in_ready & ~flush. Pop occurs when out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH).
  - It is a function of registered state only: no combinational path from out_ready.
  - When full, a simultaneous pop does not enable a push that cycle.
- Latency: a pushed entry is visible on out_valid the next cycle (no fall-through in the base build).
- Order is strict FIFO. Pointers wrap modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Empty: out_valid=0; out_pc/out_instr held at 0; out_ready is ignored.
- Full: in_ready=0; in_valid is ignored with no state change.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Next cycle: count=0, pointers=0, out_valid=0, in_ready=1.
  - A pair presented with flush high is dropped. The redirected PC's instruction arrives the following cycle.
- Reset mid-operation: immediate return to reset state regardless of pending push/pop/flush.
- No X propagation: out_pc/out_instr are muxed to 0 whenever out_valid=0.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and in_valid=1 and flush=0: out_valid=1 combinationally, with out_pc/out_instr = in_pc/in_instr.
  - If out_ready is also high, the pair is consumed without being written (count stays 0). Otherwise it is written as normal.
  - Zero-latency path for the straight-line case.
- Undefined: one-cycle minimum latency as above; no combinational in-to-out paths.

Decomposition:
- Shared package fetch_pkg:
  - localparams for AW/DW defaults.
  - typedef fetch_entry_t (struct packed {pc, instr}).
  - PC_RESET constant = 0.
- One natural sub-module: fetch_queue_mem, a DEPTH x (AW+DW) register array.
  - Synchronous write port; asynchronous read port; no reset on the data.
  - fetch_queue keeps pointers, count, flush and handshake logic.

Test Plan:
- Reset then push pc=0..3 (instr=0x1000+pc) with out_ready=0 → count=4, in_ready=0 after 4th push; a 5th push of pc=4 is ignored; release out_ready → pops 0,1,2,3 in order, then out_valid=0.
- Continuous push and pop with out_ready=1, pc=0..9 → out_pc 0..9 each one cycle after its push; count stays at 1 in steady state.
- Full queue, assert out_ready and in_valid (pc=8) together → pop of head occurs, pc=8 is not accepted that cycle, count=3, and it is accepted next cycle.
- 3 entries queued, flush=1 with in_valid=1 (pc=0x40) → next cycle count=0, out_valid=0, pc=0x40 not stored; push pc=0x20 next → out_pc=0x20 one cycle later.
- Wrap-around: push/pop 11 entries with DEPTH=4 and random out_ready → in-order delivery, no loss or duplication, count never exceeds 4.
- Async rst pulse between clock edges while count=2 → outputs return to reset values immediately, before the next edge. With FETCH_QUEUE_BYPASS_EN: empty, push pc=5 with out_ready=1 → out_valid=1 with out_pc=5 in the same cycle, and count stays 0.
